multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Parametrised, sequential successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, driving the same datapath control set plus IR/PC write enables. Memory accesses use a ready handshake with a timeout, and the block flags illegal opcodes and halts. It sits between the instruction register/memory interface and the datapath of the multicycle CPU.

Parameters:
OPCODE_W, 4, opcode width; defined opcodes are zero-extended to this width
ALU_OP_W, 3, width of alu_op; ALU codes are zero-extended
HALT_OPCODE, all ones (4'b1111 at default), opcode that enters HALT
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before bus_error; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  OPCODE_W  opcode field from IR, valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
ir_write  out  1  load IR with fetched word
pc_write  out  1  update PC
reg_dst  out  1  rd as destination (R-type)
alu_src  out  1  immediate as ALU B operand
mem_to_reg  out  1  writeback from memory data
reg_write  out  1  register file write
mem_read  out  1  memory read request
mem_write  out  1  memory write request
branch  out  1  branch target select for PC
alu_op  out  ALU_OP_W  ADD=010 SUB=110 AND=000 OR=001
illegal_op  out  1  one-cycle pulse, undefined opcode
bus_error  out  1  one-cycle pulse, mem timeout
halted  out  1  in HALT state
state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
retired_count  out  32  retired instructions (see Optional Feature)

Behaviour:
- Opcodes: ADD=0 SUB=1 AND=2 OR=3 LOAD=4 STORE=5 BRANCH=6, HALT_OPCODE; all others are illegal.
- Reset (async): state=FETCH, op_q=0, timeout counter=0, retired_count=0. Outputs are combinational from state/op_q; in FETCH after reset only mem_read=1, all others 0.
- FETCH: mem_read=1; on mem_ready: ir_write=1, pc_write=1 (PC+1), go to DECODE.
- DECODE: op_q<=opcode. Illegal: illegal_op=1, go to FETCH. HALT_OPCODE: go to HALT. Otherwise go to EXEC.
- EXEC: alu_op per op_q. R-type: alu_src=0, go to WB. LOAD/STORE: alu_src=1, alu_op=ADD, go to MEM. BRANCH: alu_op=SUB, branch=1, pc_write=zero, go to FETCH (retires).
- MEM: alu_src=1, alu_op=ADD. LOAD: mem_read=1; on mem_ready go to WB. STORE: mem_write=1; on mem_ready go to FETCH (retires).
- WB: reg_write=1. R-type: reg_dst=1, alu_op held. LOAD: mem_to_reg=1. Go to FETCH (retires).
- HALT: halted=1, all other outputs 0; stays until rst.
- Timeout: counter clears on entry to FETCH/MEM and increments each waiting cycle without mem_ready. When it reaches MEM_TIMEOUT-1 with mem_ready still low: bus_error=1, abort to FETCH, no write enables asserted, not retired. mem_ready arriving on the same cycle as the limit wins (no error).
- Minimum latency: R-type 4, LOAD 5, STORE 4, BRANCH 3 cycles with mem_ready held high.
- rst mid-instruction aborts immediately; no partial write enables follow.

Optional Feature:
PERF_COUNTER_EN: when defined, retired_count increments by 1 on each retirement (WB→FETCH, STORE MEM→FETCH, BRANCH EXEC→FETCH) and wraps at 2^32-1→0. When undefined, retired_count is tied to 0 and no counter logic is built.

Test Plan:
- mem_ready=1, ADD (0) → states 0,1,2,4,0; WB has reg_write=1, reg_dst=1, alu_op=010.
- LOAD, mem_ready low 3 cycles in MEM → mem_read held 3 cycles, then WB with mem_to_reg=1, reg_write=1.
- BRANCH with zero=1 vs zero=0 → EXEC branch=1, alu_op=110, pc_write=1 / 0 respectively.
- Opcode 7 → illegal_op pulse in DECODE, next state FETCH, no reg_write. Opcode 15 → halted=1, stays until rst.
- STORE, mem_ready never asserted, MEM_TIMEOUT=16 → bus_error after 16 MEM cycles, back to FETCH, retired_count unchanged.
- PERF_COUNTER_EN: ADD, SUB, STORE, BRANCH → retired_count=4; assert rst mid-EXEC → state=0, count=0 immediately.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath control set. Memory waits (FETCH and MEM) are bounded by
// MEM_TIMEOUT cycles (0 disables the bound), and undefined opcodes raise
// illegal_op. HALT_OPCODE parks the unit in HALT until reset.
// Optional feature macro: PERF_COUNTER_EN (retired-instruction counter).
module multicycle_control_unit #(
   parameter int                  OPCODE_W    = 4,
   parameter int                  ALU_OP_W    = 3,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE = {OPCODE_W{1'b1}},
   parameter int                  MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg_dst,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                branch,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal_op,
   output logic                bus_error,
   output logic                halted,
   output logic [2:0]          state,
   output logic [31:0]         retired_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_ADD    = OPCODE_W'(4'd0);
   localparam logic [OPCODE_W-1:0] OP_SUB    = OPCODE_W'(4'd1);
   localparam logic [OPCODE_W-1:0] OP_AND    = OPCODE_W'(4'd2);
   localparam logic [OPCODE_W-1:0] OP_OR     = OPCODE_W'(4'd3);
   localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(4'd4);
   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(4'd5);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(4'd6);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b010);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b110);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'b000);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b001);

   // Wait counter only needs to reach MEM_TIMEOUT-1.
   localparam int                TMO_W    = (MEM_TIMEOUT > 32'sd2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int                TMO_LIM  = (MEM_TIMEOUT > 32'sd0) ? (MEM_TIMEOUT - 32'sd1) : 32'sd0;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_LIM[TMO_W-1:0];
   localparam logic              TMO_EN   = (MEM_TIMEOUT > 32'sd0);

   state_t                state_q, state_d;
   logic [OPCODE_W-1:0]   op_q, op_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  waiting_s;
   logic                  timeout_s;
   logic                  illegal_s;

   function automatic logic is_defined(input logic [OPCODE_W-1:0] op);
      return (op <= OP_BRANCH);
   endfunction

   function automatic logic is_rtype(input logic [OPCODE_W-1:0] op);
      return (op <= OP_OR);
   endfunction

   function automatic logic [ALU_OP_W-1:0] alu_code(input logic [OPCODE_W-1:0] op);
      logic [ALU_OP_W-1:0] code;
      case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timeout_s = TMO_EN && waiting_s && !mem_ready && (tmo_q == TMO_LAST);
   // HALT_OPCODE takes priority over the defined set if the two ever overlap.
   assign illegal_s = (opcode != HALT_OPCODE) && !is_defined(opcode);
   assign state     = state_q;

   // Next-state, latched opcode and wait-counter update.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (opcode == HALT_OPCODE) begin
               state_d = S_HALT;
            end else if (illegal_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
               state_d = S_MEM;
            end else if (is_rtype(op_q)) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (op_q == OP_LOAD) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (timeout_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      // Counter restarts on every state entry (including a timeout re-entry).
      if ((state_d != state_q) || timeout_s) begin
         tmo_d = '0;
      end else if (waiting_s && !mem_ready) begin
         tmo_d = tmo_q + TMO_W'(1'b1);
      end else begin
         tmo_d = tmo_q;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmo_q   <= tmo_d;
      end
   end

   // Datapath controls decoded from the current state and latched opcode.
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_op     = ALU_AND;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end else begin
               bus_error = timeout_s;
            end
         end
         S_DECODE: illegal_op = illegal_s;
         S_EXEC: begin
            if (is_rtype(op_q)) begin
               alu_op = alu_code(op_q);
            end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
               alu_src = 1'b1;
               alu_op  = ALU_ADD;
            end else if (op_q == OP_BRANCH) begin
               alu_op   = ALU_SUB;
               branch   = 1'b1;
               pc_write = zero;
            end else begin
               alu_op = ALU_AND;
            end
         end
         S_MEM: begin
            alu_src   = 1'b1;
            alu_op    = ALU_ADD;
            mem_read  = (op_q == OP_LOAD);
            mem_write = (op_q == OP_STORE);
            bus_error = timeout_s;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (is_rtype(op_q)) begin
               reg_dst = 1'b1;
               alu_op  = alu_code(op_q);
            end else begin
               mem_to_reg = 1'b1;
            end
         end
         S_HALT:  halted = 1'b1;
         default: halted = 1'b0;
      endcase
   end

`ifdef PERF_COUNTER_EN
   logic [31:0] retired_q;
   logic        retire_s;

   assign retire_s = (state_q == S_WB)
                  || ((state_q == S_EXEC) && (op_q == OP_BRANCH))
                  || ((state_q == S_MEM) && (op_q == OP_STORE) && mem_ready);

   // Retired-instruction counter, wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= 32'd0;
      end else if (retire_s) begin
         retired_q <= retired_q + 32'd1;
      end else begin
         retired_q <= retired_q;
      end
   end

   assign retired_count = retired_q;
`else
   assign retired_count = 32'd0;
`endif

endmodule
